// File: rtl/bp_fpga_host_pkg.sv
// Shared NBF packet layout, opcode/response constants and FSM state types
// for the BlackParrot FPGA host I/O-out path.
package bp_fpga_host_pkg;

  localparam logic [7:0] NBF_W32    = 8'h02;
  localparam logic [7:0] NBF_W64    = 8'h03;
  localparam logic [7:0] NBF_FENCE  = 8'hFE;
  localparam logic [7:0] NBF_FINISH = 8'hFF;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int NBF_FLITS = 5;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [63:0] addr;
    logic [63:0] data;
  } bp_nbf_s;

  typedef enum logic [1:0] {
    e_idle    = 2'd0,
    e_collect = 2'd1,
    e_send    = 2'd2,
    e_bresp   = 2'd3
  } bp_wr_state_e;

  typedef enum logic {
    e_ridle = 1'b0,
    e_rresp = 1'b1
  } bp_rd_state_e;

  // Only 4B and 8B stores map onto an NBF write opcode.
  function automatic logic nbf_size_ok(input logic [2:0] size);
    case (size)
      3'b010:  nbf_size_ok = 1'b1;
      3'b011:  nbf_size_ok = 1'b1;
      default: nbf_size_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] nbf_opcode(input logic [2:0] size);
    case (size)
      3'b010:  nbf_opcode = NBF_W32;
      default: nbf_opcode = NBF_W64;
    endcase
  endfunction

  // A 4B store sits in the half of the beat selected by addr[2].
  function automatic logic [63:0] nbf_data(input logic [2:0] size, input logic [63:0] addr,
                                           input logic [63:0] wdata);
    case (size)
      3'b010:  nbf_data = {32'd0, (addr[2] ? wdata[63:32] : wdata[31:0])};
      default: nbf_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/bsg_parallel_in_serial_out.sv
// Parallel-in serial-out buffer: loads els_p flits at once and releases them
// LSB first, holding the presented flit stable until it is consumed.
module bsg_parallel_in_serial_out #(
  parameter int width_p = 32,
  parameter int els_p   = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [els_p*width_p-1:0]   i_data,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [width_p-1:0]         o_data,
  output logic                       o_last,
  input  logic                       i_yumi
);

  localparam int CNT_W = $clog2(els_p);

  logic [els_p*width_p-1:0] r_data;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_valid;

  // Load when empty, shift one flit out per consumed flit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_valid && !r_valid) begin
      r_data  <= i_data;
      r_cnt   <= '0;
      r_valid <= 1'b1;
    end else if (r_valid && i_yumi) begin
      r_data <= r_data >> width_p;
      if (o_last) begin
        r_cnt   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_data  <= r_data;
      r_cnt   <= r_cnt;
      r_valid <= r_valid;
    end
  end

  assign o_ready = ~r_valid;
  assign o_valid = r_valid;
  assign o_data  = r_data[width_p-1:0];
  assign o_last  = (r_cnt == CNT_W'(els_p - 1));

endmodule

// File: rtl/blackparrot_fpga_host_io_out.sv
// AXI4 slave turning single-beat BlackParrot I/O-out writes into 5-flit NBF
// packets on a 32b host stream; reads complete with zero data.
module blackparrot_fpga_host_io_out
  import bp_fpga_host_pkg::*;
#(
  parameter int S_AXI_ADDR_WIDTH   = 64,
  parameter int S_AXI_DATA_WIDTH   = 64,
  parameter int S_AXI_ID_WIDTH     = 4,
  parameter int fifo_data_width_p  = 32,
  parameter int nbf_opcode_width_p = 8
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awlock,
  input  logic [3:0]                    s_axi_awcache,
  input  logic [2:0]                    s_axi_awprot,
  input  logic [3:0]                    s_axi_awqos,
  input  logic [3:0]                    s_axi_awregion,
  input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arlock,
  input  logic [3:0]                    s_axi_arcache,
  input  logic [2:0]                    s_axi_arprot,
  input  logic [3:0]                    s_axi_arqos,
  input  logic [3:0]                    s_axi_arregion,
  output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic [S_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic                          host_v_o,
  output logic [fifo_data_width_p-1:0]  host_data_o,
  input  logic                          host_ready_and_i
);

  localparam int PKT_W = fifo_data_width_p * NBF_FLITS;
  localparam int PAD_W = PKT_W - $bits(bp_nbf_s);

  bp_wr_state_e                  r_wstate;
  logic                          r_awready;
  logic                          r_wready;
  logic                          r_bvalid;
  logic [1:0]                    r_bresp;
  logic [S_AXI_ID_WIDTH-1:0]     r_bid;
  logic [63:0]                   r_addr;
  logic [2:0]                    r_size;
  logic [63:0]                   r_data;
  logic                          r_first;
  logic                          r_err;

  bp_rd_state_e                  r_rstate;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [S_AXI_ID_WIDTH-1:0]     r_rid;
  logic                          r_rlast;
  logic [1:0]                    r_rresp;
  logic [7:0]                    r_rlen;
  logic [7:0]                    r_rcnt;

  logic                          w_w_fire;
  logic                          w_load;
  logic [63:0]                   w_beat_data;
  logic [63:0]                   w_pkt_data;
  logic [nbf_opcode_width_p-1:0] w_opcode;
  bp_nbf_s                       w_pkt;
  logic                          w_piso_ready;
  logic                          w_piso_v;
  logic                          w_piso_last;
  logic                          w_flit_fire;
  logic                          w_last_flit;
  logic                          w_unused;

  assign w_w_fire    = s_axi_wvalid && r_wready;
  assign w_beat_data = nbf_data(r_size, r_addr, s_axi_wdata);
  // A single-beat write is loaded straight from the bus in its W cycle.
  assign w_pkt_data  = r_first ? w_beat_data : r_data;
  assign w_opcode    = nbf_opcode(r_size);
  assign w_pkt       = '{opcode: w_opcode, addr: r_addr, data: w_pkt_data};
  assign w_load      = (r_wstate == e_collect) && w_w_fire && s_axi_wlast && !r_err;
  assign w_flit_fire = w_piso_v && host_ready_and_i;
  assign w_last_flit = w_flit_fire && w_piso_last;

  bsg_parallel_in_serial_out #(
    .width_p (fifo_data_width_p),
    .els_p   (NBF_FLITS)
  ) u_piso (
    .i_clk   (s_axi_aclk),
    .i_rst_n (s_axi_aresetn),
    .i_valid (w_load),
    .i_data  ({{PAD_W{1'b0}}, w_pkt}),
    .o_ready (w_piso_ready),
    .o_valid (w_piso_v),
    .o_data  (host_data_o),
    .o_last  (w_piso_last),
    .i_yumi  (w_flit_fire)
  );

  // Write FSM: AW -> W beats -> packet send -> B response.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_wstate  <= e_idle;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
      r_bid     <= '0;
      r_addr    <= 64'd0;
      r_size    <= 3'd0;
      r_data    <= 64'd0;
      r_first   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_wstate)
        e_idle: begin
          if (s_axi_awvalid && r_awready) begin
            r_addr    <= s_axi_awaddr;
            r_bid     <= s_axi_awid;
            r_size    <= s_axi_awsize;
            r_err     <= (s_axi_awlen != 8'd0) || !nbf_size_ok(s_axi_awsize);
            r_first   <= 1'b1;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= e_collect;
          end else begin
            r_awready <= 1'b1;
          end
        end
        e_collect: begin
          if (w_w_fire) begin
            if (r_first) begin
              r_data <= w_beat_data;
            end else begin
              r_data <= r_data;
            end
            r_first <= 1'b0;
            if (s_axi_wlast) begin
              r_wready <= 1'b0;
              if (r_err) begin
                r_bvalid <= 1'b1;
                r_bresp  <= AXI_RESP_SLVERR;
                r_wstate <= e_bresp;
              end else begin
                r_wstate <= e_send;
              end
            end else begin
              r_wready <= 1'b1;
            end
          end else begin
            r_wready <= 1'b1;
          end
        end
        e_send: begin
          if (w_last_flit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= AXI_RESP_OKAY;
            r_wstate <= e_bresp;
          end else begin
            r_wstate <= e_send;
          end
        end
        e_bresp: begin
          if (s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= e_idle;
          end else begin
            r_bvalid <= 1'b1;
          end
        end
        default: begin
          r_wstate  <= e_idle;
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: every AR returns arlen+1 zero beats; bursts flag SLVERR.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_rstate  <= e_ridle;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rid     <= '0;
      r_rlast   <= 1'b0;
      r_rresp   <= AXI_RESP_OKAY;
      r_rlen    <= 8'd0;
      r_rcnt    <= 8'd0;
    end else begin
      case (r_rstate)
        e_ridle: begin
          if (s_axi_arvalid && r_arready) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rid     <= s_axi_arid;
            r_rlen    <= s_axi_arlen;
            r_rcnt    <= 8'd0;
            r_rlast   <= (s_axi_arlen == 8'd0);
            r_rresp   <= (s_axi_arlen == 8'd0) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            r_rstate  <= e_rresp;
          end else begin
            r_arready <= 1'b1;
          end
        end
        e_rresp: begin
          if (s_axi_rready && r_rlast) begin
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= e_ridle;
          end else if (s_axi_rready) begin
            r_rcnt  <= r_rcnt + 8'd1;
            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
          end else begin
            r_rvalid <= 1'b1;
          end
        end
        default: begin
          r_rstate  <= e_ridle;
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
        end
      endcase
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bid     = r_bid;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rid     = r_rid;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = '0;
  assign host_v_o      = w_piso_v;

  assign w_unused = &{1'b0, w_piso_ready, s_axi_awburst, s_axi_awlock, s_axi_awcache,
                      s_axi_awprot, s_axi_awqos, s_axi_awregion, s_axi_wstrb, s_axi_araddr,
                      s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arcache,
                      s_axi_arprot, s_axi_arqos, s_axi_arregion};

endmodule

// File: tb/tb_blackparrot_fpga_host_io_out.sv
// Scoreboard bench: stimulus pushes expected flits/B/R; a negedge monitor pops and compares.
module tb_blackparrot_fpga_host_io_out;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] awaddr = 64'd0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  awid = 4'd0;
  logic [7:0]  awlen = 8'd0;
  logic [2:0]  awsize = 3'd0;
  logic [63:0] wdata = 64'd0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  arid = 4'd0;
  logic [7:0]  arlen = 8'd0;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        host_v;
  logic [31:0] host_data;
  logic        host_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [31:0] flit_q[$];
  logic [5:0]  b_q[$];
  logic [70:0] r_q[$];
  logic [8:0]  pat;

  always #5 clk = ~clk;

  blackparrot_fpga_host_io_out dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_awid(awid), .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(2'b01),
    .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awqos(4'd0),
    .s_axi_awregion(4'd0),
    .s_axi_wdata(wdata), .s_axi_wstrb(8'hFF), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(64'd0), .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_arid(arid),
    .s_axi_arlen(arlen), .s_axi_arsize(3'd3), .s_axi_arburst(2'b01), .s_axi_arlock(1'b0),
    .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arqos(4'd0), .s_axi_arregion(4'd0),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rid(rid), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .host_v_o(host_v), .host_data_o(host_data), .host_ready_and_i(host_ready)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out", nm);
  endtask

  task automatic push_flits(input logic [31:0] f0, input logic [31:0] f1, input logic [31:0] f2,
                            input logic [31:0] f3, input logic [31:0] f4);
    flit_q.push_back(f0); flit_q.push_back(f1); flit_q.push_back(f2);
    flit_q.push_back(f3); flit_q.push_back(f4);
  endtask

  // Monitor: compares every DUT output handshake against the scoreboard queues.
  always @(negedge clk) begin
    if (aresetn) begin
      if (host_v && host_ready) begin
        if (flit_q.size() == 0) fail_now("unexpected_flit");
        else chk("flit", 128'(host_data), 128'(flit_q.pop_front()));
      end
      if (bvalid && bready) begin
        chk("b_after_last_flit", 128'(flit_q.size()), 128'd0);
        if (b_q.size() == 0) fail_now("unexpected_b");
        else chk("b_id_resp", 128'({bid, bresp}), 128'(b_q.pop_front()));
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) fail_now("unexpected_r");
        else chk("r_id_data_last_resp", 128'({rid, rdata, rlast, rresp}), 128'(r_q.pop_front()));
      end
    end
  end

  task automatic do_write(input logic [63:0] addr, input logic [2:0] size, input logic [3:0] id,
                          input logic [7:0] len, input logic [63:0] data);
    int n;
    awaddr = addr; awsize = size; awid = id; awlen = len; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 100);
    if (!awready) begin fail_now("aw_handshake"); awvalid = 1'b0; return; end
    @(posedge clk); #1 awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = data + 64'(b); wlast = (b == int'(len)); wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!wready && n < 100);
      if (!wready) begin fail_now("w_handshake"); wvalid = 1'b0; return; end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [7:0] len);
    int n;
    arid = id; arlen = len; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 100);
    if (!arready) fail_now("ar_handshake");
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((flit_q.size() != 0 || b_q.size() != 0 || r_q.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) fail_now("drain");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_valids", 128'({awready, wready, bvalid, arready, rvalid, host_v}), 128'd0);
    chk("rst_host_data", 128'(host_data), 128'd0);
    chk("rst_resp", 128'({bresp, rresp}), 128'd0);
    @(posedge clk); #1 aresetn = 1'b1;
    @(posedge clk); #1;

    // 1: 8B write, host always ready
    push_flits(32'hCAFEF00D, 32'hDEADBEEF, 32'h00101000, 32'h0, 32'h03);
    b_q.push_back({4'd5, 2'b00});
    do_write(64'h0000_0000_0010_1000, 3'd3, 4'd5, 8'd0, 64'hDEADBEEF_CAFEF00D);
    wait_done();

    // 2: 4B write to upper half
    push_flits(32'h11223344, 32'h0, 32'h00102004, 32'h0, 32'h02);
    b_q.push_back({4'd1, 2'b00});
    do_write(64'h0000_0000_0010_2004, 3'd2, 4'd1, 8'd0, 64'h11223344_55667788);
    wait_done();

    // 2b: 4B write to lower half
    push_flits(32'h55667788, 32'h0, 32'h00102000, 32'h0, 32'h02);
    b_q.push_back({4'd1, 2'b00});
    do_write(64'h0000_0000_0010_2000, 3'd2, 4'd1, 8'd0, 64'h11223344_55667788);
    wait_done();

    // 3: host stalls 1-0-0-1 during the send
    push_flits(32'h0B0A0908, 32'h0F0E0D0C, 32'h00001230, 32'h000000AB, 32'h03);
    b_q.push_back({4'd3, 2'b00});
    pat = 9'b111111001;
    do_write(64'h0000_00AB_0000_1230, 3'd3, 4'd3, 8'd0, 64'h0F0E0D0C_0B0A0908);
    for (int i = 0; i < 9; i++) begin
      host_ready = pat[i];
      @(posedge clk); #1;
    end
    host_ready = 1'b1;
    wait_done();

    // 4: burst write drained, no flits, SLVERR; then unsupported size
    b_q.push_back({4'd6, 2'b10});
    do_write(64'h0000_0000_0000_0040, 3'd3, 4'd6, 8'd3, 64'h1);
    wait_done();
    b_q.push_back({4'd4, 2'b10});
    do_write(64'h0000_0000_0000_0044, 3'd1, 4'd4, 8'd0, 64'h2);
    wait_done();

    // 5: AR concurrent with a write, then a 2-beat read
    push_flits(32'h89ABCDEF, 32'h01234567, 32'h00000008, 32'h00000001, 32'h03);
    b_q.push_back({4'd7, 2'b00});
    r_q.push_back({4'd2, 64'd0, 1'b1, 2'b00});
    fork
      do_write(64'h0000_0001_0000_0008, 3'd3, 4'd7, 8'd0, 64'h01234567_89ABCDEF);
      do_read(4'd2, 8'd0);
    join
    wait_done();
    r_q.push_back({4'd9, 64'd0, 1'b0, 2'b10});
    r_q.push_back({4'd9, 64'd0, 1'b1, 2'b10});
    do_read(4'd9, 8'd1);
    wait_done();

    // 6: reset while the third flit is presented
    host_ready = 1'b0;
    push_flits(32'h44444444, 32'h33333333, 32'h00000030, 32'h0, 32'h03);
    b_q.push_back({4'd8, 2'b00});
    do_write(64'h0000_0000_0000_0030, 3'd3, 4'd8, 8'd0, 64'h33333333_44444444);
    host_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 host_ready = 1'b0;
    chk("pre_reset_flit3", 128'({host_v, host_data}), 128'({1'b1, 32'h00000030}));
    aresetn = 1'b0;
    #1;
    chk("reset_abort", 128'({host_v, bvalid, awready}), 128'd0);
    flit_q.delete();
    b_q.delete();
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    host_ready = 1'b1;
    @(posedge clk); #1;
    push_flits(32'h5A5A5A5A, 32'hA5A5A5A5, 32'h00000020, 32'h0, 32'h03);
    b_q.push_back({4'd9, 2'b00});
    do_write(64'h0000_0000_0000_0020, 3'd3, 4'd9, 8'd0, 64'hA5A5A5A5_5A5A5A5A);
    wait_done();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
